mux_stream_rr: RTL and testbench

Parametrised successor to the team's 4:1 combinational mux. It selects one of NCH valid/ready input channels of WIDTH bits and forwards it through a single registered output stage. Two modes are supported: direct select, driven by an external sel, and round-robin arbitration. It sits between multiple producer agents and a single consumer in the mux testbench environment.

---
 rtl/mux_stream_rr.sv | 143 ++++++++++++++
 tb/tb_mux_stream_rr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_rr.sv
// mux_stream_rr: NCH-way valid/ready stream multiplexer with one registered
// output stage. The channel is chosen either directly by sel or by a
// round-robin arbiter whose pointer survives mode changes.
module mux_stream_rr #(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

    mode_e              mode_s;
    logic               load_en;
    logic               dir_ok;
    logic               rr_hi_found;
    logic               rr_lo_found;
    logic [SELW-1:0]    rr_hi_idx;
    logic [SELW-1:0]    rr_lo_idx;
    logic               grant_ok;
    logic [SELW-1:0]    grant;
    logic [NCH-1:0]     grant_oh;
    logic [WIDTH-1:0]   grant_data;
    logic               xfer;

    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SELW-1:0]    out_ch_q,    out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic [SELW-1:0]    last_q,      last_d;

    assign mode_s  = mode_e'(mode);
    assign load_en = !out_valid_q || out_ready;
    assign dir_ok  = ({1'b0, sel} < NCH_W);

    // Round-robin search split into two ascending scans: channels above the
    // pointer first, then wrap to channels at or below it. Equivalent to the
    // modulo walk last+1, last+2, ... without a variable rotate.
    always_comb begin
        rr_hi_found = 1'b0;
        rr_lo_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (in_valid[i]) begin
                if (SELW'(i) > last_q) begin
                    if (!rr_hi_found) begin
                        rr_hi_found = 1'b1;
                        rr_hi_idx   = SELW'(i);
                    end
                end else begin
                    if (!rr_lo_found) begin
                        rr_lo_found = 1'b1;
                        rr_lo_idx   = SELW'(i);
                    end
                end
            end
        end
    end

    // Pick the granted channel for the active mode.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        if (mode_s == MODE_RR) begin
            grant_ok = rr_hi_found || rr_lo_found;
            grant    = rr_hi_found ? rr_hi_idx : rr_lo_idx;
        end else begin
            grant_ok = dir_ok;
            grant    = sel;
        end
    end

    // One-hot grant and the data word of the granted channel.
    always_comb begin
        grant_oh   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_ok && (grant == SELW'(i))) begin
                grant_oh[i] = 1'b1;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is withheld during reset so no producer sees a handshake that
    // the reset is about to discard.
    assign in_ready = (load_en && !rst) ? grant_oh : '0;
    assign xfer     = |(in_ready & in_valid);

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (mode_s == MODE_RR) begin
                last_d = grant;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; pointer resets so ch0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: directed scenarios against fixed
// expected values, then randomized traffic against a behavioural model.
module tb_mux_stream_rr;

    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_ch    = 0;
    int               m_last  = NCH - 1;

    always #5 clk = ~clk;

    mux_stream_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Granted channel under the current inputs, -1 for none.
    function automatic int model_grant();
        if (mode == 1'b0) return (int'(sel) < NCH) ? int'(sel) : -1;
        for (int k = 1; k <= NCH; k++) begin
            int c = (m_last + k) % NCH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        int g = model_grant();
        logic [NCH-1:0] r = '0;
        if (rst || g < 0 || (m_valid && !out_ready)) return r;
        r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_update();
        int g  = model_grant();
        bit le = !m_valid || out_ready;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = NCH - 1;
        end else if (g >= 0 && le && in_valid[g]) begin
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_ch    = g;
            m_valid = 1'b1;
            if (mode) m_last = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'hF;
        in_data = 16'hDCBA; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
            tick();
            n_tests++; if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 2'd0) begin
                n_fail++; $display("FAIL reset_outputs: got v=%b d=%h ch=%0d expected v=0 d=0 ch=0", out_valid, out_data, out_ch); end
        end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 4'hA) begin
            n_fail++; $display("FAIL reset_first_word: got v=%b d=%h ch=%0d expected v=1 d=a ch=0", out_valid, out_data, out_ch); end
    endtask

    task automatic test_direct();
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = SELW'(s);
            #1;
            n_tests++; if (in_ready !== (4'b0001 << s)) begin n_fail++; $display("FAIL direct_ready sel=%0d: got %b expected %b", s, in_ready, 4'b0001 << s); end
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_ch !== SELW'(s) || out_data !== WIDTH'(4'hA + s)) begin
                n_fail++; $display("FAIL direct_word sel=%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d", s, out_valid, out_data, out_ch, WIDTH'(4'hA + s), s); end
        end
        in_valid = 4'h0; sel = 2'd2;
        #1;
        n_tests++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL direct_ready_novalid: got %b expected 0100", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || out_data !== 4'hD || out_ch !== 2'd3) begin
            n_fail++; $display("FAIL direct_drain_hold: got v=%b d=%h ch=%0d expected v=0 d=d ch=3", out_valid, out_data, out_ch); end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        mode = 1'b1; in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_ch !== SELW'(i % 4) || out_data !== WIDTH'(4'hA + i % 4)) begin
                n_fail++; $display("FAIL rr_all cycle %0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d", i, out_valid, out_ch, out_data, i % 4); end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_ch !== ((i % 2 == 0) ? 2'd1 : 2'd3)) begin
                n_fail++; $display("FAIL rr_odd cycle %0d: got v=%b ch=%0d expected v=1 ch=%0d", i, out_valid, out_ch, (i % 2 == 0) ? 1 : 3); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b1; in_valid = 4'b0100; in_data = 16'h0500; out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 4'h5) begin
            n_fail++; $display("FAIL bp_load: got v=%b d=%h ch=%0d expected v=1 d=5 ch=2", out_valid, out_data, out_ch); end
        out_ready = 1'b0; in_valid = 4'b1100; in_data = 16'h7500;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready cycle %0d: got %b expected 0000", c, in_ready); end
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 4'h5) begin
                n_fail++; $display("FAIL bp_stall_hold cycle %0d: got v=%b d=%h ch=%0d expected v=1 d=5 ch=2", c, out_valid, out_data, out_ch); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1000", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 4'h7) begin
            n_fail++; $display("FAIL bp_next_word: got v=%b d=%h ch=%0d expected v=1 d=7 ch=3", out_valid, out_data, out_ch); end
        in_valid = 4'h0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mode = 1'b1; in_valid = 4'b0010; in_data = 16'h0030; out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 4'h3) begin
            n_fail++; $display("FAIL b2b_first: got v=%b d=%h ch=%0d expected v=1 d=3 ch=1", out_valid, out_data, out_ch); end
        in_valid = 4'b0001; in_data = 16'h0009;
        #1;
        n_tests++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL b2b_ready: got %b expected 0001", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 4'h9) begin
            n_fail++; $display("FAIL b2b_second: got v=%b d=%h ch=%0d expected v=1 d=9 ch=0", out_valid, out_data, out_ch); end
        in_valid = 4'h0;
        tick();
        n_tests++; if (out_valid !== 1'b0 || out_data !== 4'h9) begin
            n_fail++; $display("FAIL b2b_drain: got v=%b d=%h expected v=0 d=9", out_valid, out_data); end
    endtask

    task automatic test_reset_mode_switch();
        do_reset();
        mode = 1'b1; in_valid = 4'b0001; in_data = 16'h000E; out_ready = 1'b0;
        tick();
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 4'hE) begin
            n_fail++; $display("FAIL rm_held: got v=%b d=%h expected v=1 d=e", out_valid, out_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 2'd0) begin
            n_fail++; $display("FAIL rm_discard: got v=%b d=%h ch=%0d expected v=0 d=0 ch=0", out_valid, out_data, out_ch); end
        in_valid = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_ptr_reset: got %b expected 0001", in_ready); end
        in_valid = 4'b0010;
        #1;
        n_tests++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_ch1_ready: got %b expected 0010", in_ready); end
        tick();
        n_tests++; if (out_ch !== 2'd1 || out_data !== 4'hB) begin n_fail++; $display("FAIL rm_ch1_word: got ch=%0d d=%h expected ch=1 d=b", out_ch, out_data); end
        mode = 1'b0; sel = 2'd3; in_valid = 4'hF;
        #1;
        n_tests++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL rm_direct_ready: got %b expected 1000", in_ready); end
        tick();
        n_tests++; if (out_ch !== 2'd3 || out_data !== 4'hD) begin n_fail++; $display("FAIL rm_direct_word: got ch=%0d d=%h expected ch=3 d=d", out_ch, out_data); end
        mode = 1'b1;
        #1;
        n_tests++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_rr_resume: got %b expected 0100", in_ready); end
        tick();
        n_tests++; if (out_ch !== 2'd2 || out_data !== 4'hC) begin n_fail++; $display("FAIL rm_rr_word: got ch=%0d d=%h expected ch=2 d=c", out_ch, out_data); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] exp_rdy;
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = SELW'($urandom);
            in_valid  = NCH'($urandom);
            in_data   = (NCH*WIDTH)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = model_ready();
            n_tests++; if (in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready cycle %0d: got %b expected %b", n, in_ready, exp_rdy); end
            tick();
            n_tests++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== SELW'(m_ch)) begin
                n_fail++; $display("FAIL rand_out cycle %0d: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                                   n, out_valid, out_data, out_ch, m_valid, m_data, m_ch); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_rr_fairness();
        test_backpressure();
        test_back_to_back();
        test_reset_mode_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
